alu_host_sequencer: RTL
=======================

Name: alu_host_sequencer

Overview:
- Upstream front-end for the multi-cycle ALU core: accepts one request (op plus two 8-bit operands) over a valid/ready handshake.
- Serialises the operands onto the core's 8-bit inbus with a one-cycle start pulse.
- Detects completion from the core's 4-bit state output and captures the 16-bit outbus into a held response register with valid/ready.
- Adds timeout detection so a hung core never stalls the host.

Parameters:
- A_HOLD, 1: cycles operand A is driven on alu_inbus, counted from the start cycle; legal range 1-15.
- B_HOLD, 1: cycles operand B is driven on alu_inbus after A; legal range 1-15.
- DONE_STATE, 4'd15: value of alu_state that marks a finished operation.
- TIMEOUT, 64: max WAIT cycles before aborting; legal range 2-255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
- req_a  input  8  first operand.
- req_b  input  8  second operand.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  host consumes the response.
- rsp_data  output  16  captured ALU result.
- rsp_err  output  1  1 = timeout; rsp_data = 16'h0000.
- alu_start  output  1  start pulse to the core.
- alu_op  output  2  op to the core.
- alu_inbus  output  8  operand bus to the core.
- alu_outbus  input  16  core result.
- alu_state  input  4  core state, used for done detection.

Behaviour:
- Reset values: req_ready=0 during rst, 1 the cycle after; rsp_valid=0, rsp_data=0, rsp_err=0, alu_start=0, alu_op=0, alu_inbus=0.
  - All internal registers clear and the FSM goes to IDLE.
  - Reset mid-operation aborts immediately and produces no response.
- FSM states: IDLE, DRV_A, DRV_B, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational: state==IDLE).
  - On req_valid&&req_ready: register op/a/b, load hold counter = A_HOLD, go to DRV_A.
- DRV_A:
  - alu_inbus=a_reg, alu_op=op_reg.
  - alu_start=1 only on the first DRV_A cycle; exactly one pulse per request.
  - After A_HOLD cycles: load counter = B_HOLD, go to DRV_B.
- DRV_B:
  - alu_inbus=b_reg.
  - After B_HOLD cycles: clear timeout counter, go to WAIT.
- WAIT:
  - alu_inbus=0.
  - Done = (alu_state==DONE_STATE) && (prev_state!=DONE_STATE), where prev_state is alu_state registered every cycle. This edge qualification ignores a DONE left over from the previous op.
  - On done: rsp_data <= alu_outbus, sampled the same cycle; rsp_err <= 0; go to RESP.
  - Timeout counter increments each WAIT cycle. If TIMEOUT is reached without done: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - The next request is accepted no earlier than the cycle after rsp_valid drops; no overlap, single outstanding op.
- alu_op holds op_reg stable from DRV_A until RESP exits, then returns to 0.
- Latency: request accept to alu_start = 1 cycle. alu_start to first WAIT cycle = A_HOLD+B_HOLD cycles. Done edge to rsp_valid = 1 cycle.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- All counters saturate; no wrap-around.

Test Plan:
- Reset mid-WAIT (rsp_valid=0): rst for 1 cycle -> next cycle IDLE, req_ready=1, alu_start=0, rsp_valid stays 0, no response ever emitted.
- mul 0x0C*0x0A, defaults, core model reaches DONE_STATE 8 cycles after start with outbus=0x0078:
  - alu_start exactly 1 cycle after accept; inbus 0x0C then 0x0A.
  - rsp_valid 1 cycle after the done edge; rsp_data=16'h0078, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stays constant, req_ready=0. rsp_ready=1 -> rsp_valid drops next cycle, req_ready=1.
- Stale done: alu_state already at DONE_STATE when WAIT is entered and stays there -> no capture. The core drops to 0 then returns to DONE with outbus=0x00FF -> rsp_data=16'h00FF.
- Timeout: core never reaches DONE_STATE -> exactly TIMEOUT=64 WAIT cycles later rsp_valid=1, rsp_err=1, rsp_data=0. The next request completes normally.
- Hold params A_HOLD=2, B_HOLD=3, add 0x05+0x03:
  - inbus=0x05 for 2 cycles, then 0x03 for 3 cycles; alu_start high for 1 cycle only.
  - rsp_data=16'h0008.

Source files
------------

// File: rtl/alu_host_sequencer.sv
// Host-side front-end for the multi-cycle ALU core: accepts one request, serialises
// the operands onto alu_inbus, waits for a done edge (or timeout) and holds the result.
module alu_host_sequencer #(
  parameter int unsigned A_HOLD     = 1,
  parameter int unsigned B_HOLD     = 1,
  parameter logic [3:0]  DONE_STATE = 4'd15,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic [3:0]  alu_state
);

  typedef enum logic [2:0] {IDLE, DRV_A, DRV_B, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  op_reg;
  logic [7:0]  a_reg, b_reg;
  logic [3:0]  hcnt;
  logic [7:0]  tcnt;
  logic [3:0]  prev_state;
  logic        done, tmo;

  // Edge-qualified done so a DONE left over from the previous op is ignored.
  assign done = (alu_state == DONE_STATE) && (prev_state != DONE_STATE);
  assign tmo  = (tcnt >= 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_start = 1'b0;
    alu_op    = '0;
    alu_inbus = '0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nx = DRV_A;
      end
      DRV_A: begin
        alu_op    = op_reg;
        alu_inbus = a_reg;
        alu_start = (hcnt == 4'(A_HOLD));
        if (hcnt <= 4'd1) state_nx = DRV_B;
      end
      DRV_B: begin
        alu_op    = op_reg;
        alu_inbus = b_reg;
        if (hcnt <= 4'd1) state_nx = WAIT;
      end
      WAIT: begin
        alu_op = op_reg;
        if (done || tmo) state_nx = RESP;
      end
      RESP: begin
        alu_op    = op_reg;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      hcnt       <= '0;
      tcnt       <= '0;
      prev_state <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      prev_state <= alu_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_reg <= req_op;
            a_reg  <= req_a;
            b_reg  <= req_b;
            hcnt   <= 4'(A_HOLD);
          end
        end
        DRV_A: begin
          if (hcnt <= 4'd1) hcnt <= 4'(B_HOLD);
          else              hcnt <= hcnt - 4'd1;
        end
        DRV_B: begin
          if (hcnt <= 4'd1) tcnt <= '0;
          else              hcnt <= hcnt - 4'd1;
        end
        WAIT: begin
          // Done takes priority over a simultaneous timeout.
          if (done) begin
            rsp_data <= alu_outbus;
            rsp_err  <= 1'b0;
          end else if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
